q_frag_ctl_loader: RTL and testbench
====================================

# q_frag_ctl_loader

Serial configuration loader that drives the per-cell control inputs (QDS, QEN, QST, QRT) of an array of NUM_CELLS Q_FRAG flip-flop fragments in the PP3 logic cell model. It sits directly upstream of the Q_FRAG array. It accepts a bit-serial control frame over a valid/ready handshake and collects it in a shadow register. After a parity check and a legality check, it commits the frame atomically to the outputs, so no Q_FRAG ever sees a partially loaded control set.

## Interface
Parameters:
- NUM_CELLS, 8, number of Q_FRAG instances driven (1..64). Frame payload = 4*NUM_CELLS bits.

Ports:
- QCK  in  1  clock; all state is updated on the rising edge.
- QRT_N  in  1  asynchronous, active-low reset.
- CFG_LOAD  in  1  start/restart frame; sampled every cycle.
- CFG_DI  in  1  serial config bit.
- CFG_VALID  in  1  CFG_DI is valid.
- CFG_READY  out  1  loader accepts a bit this cycle.
- QDS  out  NUM_CELLS  per-cell D-source select: 0 = CZI (INT), 1 = QDI (EXT).
- QEN  out  NUM_CELLS  per-cell FF enable.
- QST  out  NUM_CELLS  per-cell FF set.
- QRT  out  NUM_CELLS  per-cell FF reset.
- BUSY  out  1  frame in progress (state is not IDLE).
- DONE  out  1  one-cycle pulse: frame committed.
- ERR  out  1  one-cycle pulse: frame rejected.

## Operation
- States: IDLE, SHIFT, PARITY.
- Transfer: a bit transfers on any rising edge where CFG_VALID && CFG_READY.
- CFG_READY: combinational, 1 in SHIFT or PARITY, 0 in IDLE.
- IDLE to SHIFT: on CFG_LOAD=1. Bit counter cleared to 0, parity accumulator cleared to 0.
- SHIFT, per transfer: shadow[cnt] <= CFG_DI, parity ^= CFG_DI, cnt++.
  - Stream bit k maps to cell k/4, field k%4: 0=QDS, 1=QEN, 2=QST, 3=QRT.
  - Cell 0 is sent first.
- SHIFT to PARITY: on the transfer where cnt == 4*NUM_CELLS-1.
  - cnt width = clog2(4*NUM_CELLS+1). cnt never wraps.
- PARITY: the next transfer is the even-parity bit (XOR of all payload bits and the parity bit must be 0). State returns to IDLE on this edge.
  - Accept when parity is correct and no cell has QST=QRT=1: outputs <= shadow and DONE <= 1.
  - Reject otherwise: outputs keep their previous values and ERR <= 1.
- Restart: CFG_LOAD=1 in SHIFT or PARITY discards the shadow contents and restarts at cnt=0 in SHIFT.
  - No DONE or ERR is produced for the discarded frame.
  - Any bit presented in the same cycle is ignored.
- CFG_VALID while in IDLE: ignored.
- Shadow register is never visible on the outputs except through a commit.
- Reset values (QRT_N=0, applied immediately, independent of QCK):
  - QDS=0, QEN=all 1, QST=0, QRT=0.
  - DONE=0, ERR=0, state=IDLE, cnt=0, parity=0, shadow=0.
  - Therefore CFG_READY=0 and BUSY=0.
- Reset mid-frame: frame is lost, outputs return to reset values, no pulse is generated.

## Timing
- All outputs are registered except CFG_READY and BUSY, which are decoded from state with no input path.
- Frame latency with CFG_VALID held high:
  - CFG_LOAD sampled at edge 0.
  - Payload transfers at edges 1..4N; parity bit at edge 4N+1.
  - New QDS/QEN/QST/QRT and DONE become visible after edge 4N+1.
  - DONE or ERR is high for exactly one cycle.
- Gaps (CFG_VALID=0) stall the frame indefinitely without state change.
- Back-to-back: CFG_LOAD may be asserted in the same cycle that DONE or ERR is high. The loader is in IDLE then, so the new frame starts at the next edge.
- Reset release: the first edge after QRT_N deasserts may sample CFG_LOAD.

## Test plan
- Reset: NUM_CELLS=2, assert QRT_N=0 mid-cycle -> immediately QDS=2'b00, QEN=2'b11, QST=2'b00, QRT=2'b00, BUSY=0, CFG_READY=0.
- Good frame: NUM_CELLS=2, CFG_LOAD, stream 1,1,0,0, 0,1,1,0, parity 0 with VALID held high.
  - DONE pulses after the 9th transfer.
  - QDS=2'b01, QEN=2'b11, QST=2'b10, QRT=2'b00.
  - Outputs do not change before that edge.
- Bad parity: same payload with parity 1 -> ERR for one cycle, outputs unchanged from the prior commit, state IDLE.
- Illegal cell: stream 0,1,1,1, 0,1,0,0, parity 0 (cell 0 has QST=QRT=1) -> ERR, no commit.
- Restart and stall: CFG_LOAD again after 5 bits, then send the good frame with random VALID gaps -> exactly one DONE, values as in the good-frame case, no ERR.
- Mid-frame reset: QRT_N pulsed low after 3 bits -> reset values, no DONE/ERR, next full good frame commits normally.

Source files
------------

// File: rtl/q_frag_ctl_loader.sv
// Serial control-frame loader for an array of Q_FRAG cells: shifts a frame into a
// shadow register, checks parity and set/reset legality, then commits it atomically.
module q_frag_ctl_loader #(
  parameter int NUM_CELLS = 8
) (
  input  logic                 QCK,
  input  logic                 QRT_N,
  input  logic                 CFG_LOAD,
  input  logic                 CFG_DI,
  input  logic                 CFG_VALID,
  output logic                 CFG_READY,
  output logic [NUM_CELLS-1:0] QDS,
  output logic [NUM_CELLS-1:0] QEN,
  output logic [NUM_CELLS-1:0] QST,
  output logic [NUM_CELLS-1:0] QRT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR
);

  localparam int PAY   = 4 * NUM_CELLS;
  localparam int CNT_W = $clog2(PAY + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 par_q, par_d;
  logic [PAY-1:0]       shadow_q, shadow_d;
  logic [NUM_CELLS-1:0] qds_q, qds_d, qen_q, qen_d, qst_q, qst_d, qrt_q, qrt_d;
  logic                 done_q, done_d, err_q, err_d;
  logic                 legal;

  always_ff @(posedge QCK or negedge QRT_N) begin
    if (!QRT_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      shadow_q <= '0;
      qds_q    <= '0;
      qen_q    <= '1;
      qst_q    <= '0;
      qrt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      shadow_q <= shadow_d;
      qds_q    <= qds_d;
      qen_q    <= qen_d;
      qst_q    <= qst_d;
      qrt_q    <= qrt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    shadow_d = shadow_q;
    qds_d    = qds_q;
    qen_d    = qen_q;
    qst_d    = qst_q;
    qrt_d    = qrt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    // A cell asking for set and reset at once is never allowed onto the outputs.
    legal = 1'b1;
    for (int c = 0; c < NUM_CELLS; c++) begin
      if (shadow_q[4*c+2] && shadow_q[4*c+3]) legal = 1'b0;
    end

    if (CFG_LOAD) begin
      // Start or restart: whatever was shifted so far is dropped silently.
      state_d  = SHIFT;
      cnt_d    = '0;
      par_d    = 1'b0;
      shadow_d = '0;
    end else begin
      case (state_q)
        SHIFT: begin
          if (CFG_VALID) begin
            for (int i = 0; i < PAY; i++) begin
              if (cnt_q == CNT_W'(i)) shadow_d[i] = CFG_DI;
            end
            par_d = par_q ^ CFG_DI;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(PAY - 1)) state_d = PARITY;
          end
        end
        PARITY: begin
          if (CFG_VALID) begin
            state_d = IDLE;
            if (!(par_q ^ CFG_DI) && legal) begin
              for (int c = 0; c < NUM_CELLS; c++) begin
                qds_d[c] = shadow_q[4*c];
                qen_d[c] = shadow_q[4*c+1];
                qst_d[c] = shadow_q[4*c+2];
                qrt_d[c] = shadow_q[4*c+3];
              end
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign CFG_READY = (state_q != IDLE);
  assign BUSY      = (state_q != IDLE);
  assign QDS       = qds_q;
  assign QEN       = qen_q;
  assign QST       = qst_q;
  assign QRT       = qrt_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_q_frag_ctl_loader.sv
// Scoreboard bench for q_frag_ctl_loader with NUM_CELLS=2: stimulus pushes the
// expected commit/reject response, a negedge monitor pops it when DONE or ERR fires.
module tb_q_frag_ctl_loader;

  logic       QCK = 1'b0;
  logic       QRT_N = 1'b0;
  logic       CFG_LOAD = 1'b0;
  logic       CFG_DI = 1'b0;
  logic       CFG_VALID = 1'b0;
  logic       CFG_READY;
  logic [1:0] QDS, QEN, QST, QRT;
  logic       BUSY, DONE, ERR;

  int n_cmp = 0;
  int n_bad = 0;

  // {done, err, qds, qen, qst, qrt}
  logic [9:0] sb[$];

  // Frames as {parity, b7..b0}; bit k goes to cell k/4, field k%4.
  localparam logic [8:0] F_GOOD    = 9'b0_0110_0011;
  localparam logic [8:0] F_BADPAR  = 9'b1_0110_0011;
  localparam logic [8:0] F_ILLEGAL = 9'b0_0010_1110;
  localparam logic [7:0] O_RESET   = {2'b00, 2'b11, 2'b00, 2'b00};
  localparam logic [7:0] O_GOOD    = {2'b01, 2'b11, 2'b10, 2'b00};

  q_frag_ctl_loader #(.NUM_CELLS(2)) dut (
    .QCK(QCK), .QRT_N(QRT_N), .CFG_LOAD(CFG_LOAD), .CFG_DI(CFG_DI),
    .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY), .QDS(QDS), .QEN(QEN),
    .QST(QST), .QRT(QRT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 QCK = ~QCK;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge QCK) begin
    if (DONE === 1'b1 || ERR === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got done=%b err=%b, want none (t=%0t)", DONE, ERR, $time);
      end else begin
        check("response", 16'({DONE, ERR, QDS, QEN, QST, QRT}), 16'(sb.pop_front()));
      end
    end
  end

  task automatic start_frame();
    CFG_LOAD = 1'b1;
    CFG_VALID = 1'b1;
    CFG_DI = 1'b1;
    @(posedge QCK); #1;
    CFG_LOAD = 1'b0;
    check("busy_after_load", 16'(BUSY), 16'd1);
    check("ready_after_load", 16'(CFG_READY), 16'd1);
  endtask

  task automatic send_bits(input logic [8:0] f, input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        CFG_VALID = 1'b0;
        CFG_DI = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) begin
          @(posedge QCK); #1;
        end
      end
      CFG_VALID = 1'b1;
      CFG_DI = f[k];
      @(posedge QCK); #1;
    end
    CFG_VALID = 1'b0;
  endtask

  // Sends a complete frame; before the parity edge the outputs must still show prior.
  task automatic send_frame(input logic [8:0] f, input logic [9:0] exp,
                            input logic [7:0] prior, input bit gaps);
    send_bits(f, 8, gaps);
    check("hold_before_commit", 16'({QDS, QEN, QST, QRT}), 16'(prior));
    check("no_pulse_before_commit", 16'({DONE, ERR}), 16'd0);
    sb.push_back(exp);
    CFG_VALID = 1'b1;
    CFG_DI = f[8];
    @(posedge QCK); #1;
    CFG_VALID = 1'b0;
    check("idle_after_frame", 16'({BUSY, CFG_READY}), 16'd0);
  endtask

  initial begin
    // Reset asserted from time 0; look mid-cycle.
    #12;
    check("rst_outputs", 16'({QDS, QEN, QST, QRT}), 16'(O_RESET));
    check("rst_busy_ready", 16'({BUSY, CFG_READY}), 16'd0);
    check("rst_pulses", 16'({DONE, ERR}), 16'd0);
    #11 QRT_N = 1'b1;
    @(posedge QCK); #1;

    // Good frame.
    start_frame();
    send_frame(F_GOOD, {2'b10, O_GOOD}, O_RESET, 1'b0);

    // Bad parity, loaded back-to-back in the DONE cycle.
    check("done_visible_before_reload", 16'(DONE), 16'd1);
    start_frame();
    send_frame(F_BADPAR, {2'b01, O_GOOD}, O_GOOD, 1'b0);

    // Cell 0 with set and reset both high.
    start_frame();
    send_frame(F_ILLEGAL, {2'b01, O_GOOD}, O_GOOD, 1'b0);
    check("outputs_after_illegal", 16'({QDS, QEN, QST, QRT}), 16'(O_GOOD));

    // Restart after 5 bits, then the good frame with stalls.
    start_frame();
    send_bits(F_ILLEGAL, 5, 1'b0);
    start_frame();
    send_frame(F_GOOD, {2'b10, O_GOOD}, O_GOOD, 1'b1);

    // Mid-frame asynchronous reset after 3 bits.
    start_frame();
    send_bits(F_GOOD, 3, 1'b0);
    #3 QRT_N = 1'b0;
    #1;
    check("async_rst_outputs", 16'({QDS, QEN, QST, QRT}), 16'(O_RESET));
    check("async_rst_busy", 16'({BUSY, CFG_READY}), 16'd0);
    #2 QRT_N = 1'b1;
    @(posedge QCK); #1;
    start_frame();
    send_frame(F_GOOD, {2'b10, O_GOOD}, O_RESET, 1'b0);

    repeat (5) @(posedge QCK);
    #1;
    check("scoreboard_drained", 16'(sb.size()), 16'd0);
    check("final_outputs", 16'({QDS, QEN, QST, QRT}), 16'(O_GOOD));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
